dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the CPU MEM stage and a debug/loader port (program/data load, memory inspection).
- Arbitrates between the two requesters and sequences each access through a multi-cycle protocol: issue, latency wait, acknowledge.
- Drives a stall to the pipeline while a CPU access is outstanding.
- Sits between the EX/MEM pipeline register outputs and the data memory macro.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, address width (byte address passed through unchanged).
- MEM_LAT, 1, memory read latency in cycles from mem_en; must be >= 1.
- STARVE_MAX, 4, consecutive cycles a waiting dbg request may lose before it is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid when cpu_ack = 1.
- cpu_stall  out  1  pipeline stall, combinational: cpu_req & ~cpu_ack.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  1 = write.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  read data; valid when dbg_ack = 1.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata, busy.
  - Starve counter and latency counter are cleared.
  - An in-flight access is aborted without an ack; requesters must re-request.
- All outputs are registered except cpu_stall.
- FSM:
  - IDLE:
    - No request: stay in IDLE.
    - Request present: choose the winner, latch the grant id and the winner's addr/we/wdata into the mem_* registers, go to ISSUE.
  - ISSUE (1 cycle): mem_en = 1, mem_we = latched we; latency counter loads MEM_LAT-1; go to WAIT.
  - WAIT: mem_en = 0; decrement the counter each cycle; when counter = 0, capture mem_rdata into the granted requester's rdata register (reads only) and go to ACK.
  - ACK (1 cycle): granted requester's ack = 1; go to IDLE.
- Timing: request seen in IDLE at cycle 0 gives mem_en at cycle 1 and ack at cycle MEM_LAT+2.
- Writes follow the same sequence. The rdata register is not updated on a write.
- Arbitration (IDLE only):
  - cpu_req has priority.
  - Exception: when starve_cnt >= STARVE_MAX and dbg_req = 1, dbg wins.
- Starve counter:
  - Increments (saturating at STARVE_MAX) every cycle dbg_req = 1 and dbg is not the current grant.
  - Clears when dbg is granted or when dbg_req = 0.
- Requesters must hold req/addr/we/wdata stable until ack. If req is still high in the cycle after ack, it is treated as a new request.
- Requests arriving in ISSUE, WAIT or ACK are ignored until IDLE.
- Simultaneous requests with starve_cnt < STARVE_MAX: CPU wins, dbg waits.
- Memory address width is not checked; wrap-around is the memory's concern.

Decomposition:
- Shared package contents:
  - FSM state enum {IDLE, ISSUE, WAIT, ACK}.
  - Grant id constants GNT_CPU = 0, GNT_DBG = 1.
  - Default DATA_W/ADDR_W.
- One sub-module: dmem_arb_starve_ctr, the saturating starve counter with inputs req, granted and outputs force.

Test Plan:
- MEM_LAT = 1: cpu read of 0x10 with memory returning 0xDEADBEEF -> mem_en high with mem_addr = 0x10 in cycle 1; cpu_ack and cpu_rdata = 0xDEADBEEF in cycle 3; cpu_stall = 1 in cycles 0–2 and 0 in cycle 3.
- dbg write 0x0000_00AA to 0x20 -> single cycle with mem_en = mem_we = 1, mem_wdata = 0xAA; dbg_ack after MEM_LAT+2; dbg_rdata unchanged.
- cpu_req and dbg_req rise together, STARVE_MAX = 4, CPU issues back-to-back requests -> CPU wins the first arbitrations; dbg wins once starve_cnt reaches 4; starve_cnt returns to 0 after the dbg grant.
- MEM_LAT = 3: cpu read -> mem_en in cycle 1; cpu_ack in cycle 5; cpu_rdata equals mem_rdata sampled at cycle 4.
- rst driven to 0 during WAIT -> all outputs immediately 0, no ack is ever produced; after release, a re-issued request completes normally.
- Request raised during WAIT by the other requester -> ignored until IDLE, then granted; its ack arrives MEM_LAT+2 cycles after that IDLE cycle.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
//   state_t          : access sequencer states
//   GNT_CPU/GNT_DBG  : grant id encoding (which requester owns the access)
//   DEF_DATA_W/ADDR_W: default bus widths
package dmem_port_arbiter_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 32;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DBG = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } state_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating starve counter for the debug requester.
//   clk, rst  : clock, async active-low reset
//   req       : debug request pending
//   granted   : debug owns (or is being given) the memory this cycle
//   force_win : debug has waited STARVE_MAX cycles and must win next arbitration
module dmem_arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic granted,
   output logic force_win
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!req || granted) begin
         cnt <= '0;
      end else if (cnt != CNT_W'(STARVE_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign force_win = req && (cnt >= CNT_W'(STARVE_MAX));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port synchronous data memory between the CPU MEM stage
// and a debug/loader port. Each access runs issue -> latency wait -> ack.
//   clk, rst                               : clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata   : CPU request/response
//   cpu_stall                              : cpu_req & ~cpu_ack (combinational)
//   dbg_req/we/addr/wdata, dbg_ack/rdata   : debug request/response
//   mem_en/we/addr/wdata, mem_rdata        : memory macro interface
//   busy                                   : sequencer not idle
//
// state | meaning
// IDLE  | arbitrate; latch winner's command into mem_* registers
// ISSUE | mem_en strobe high for one cycle, load latency counter
// WAIT  | count down memory latency, capture read data at zero
// ACK   | one-cycle ack pulse to the granted requester
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   state_t           state;
   logic             gnt;
   logic [LAT_W-1:0] lat_cnt;
   logic             force_win;
   logic             dbg_wins;
   logic             dbg_granted;

   // CPU has priority unless debug has been starved long enough.
   assign dbg_wins = dbg_req && (force_win || !cpu_req);

   // Debug counts as granted both at the arbitration instant and for the whole
   // access it owns, so it never accrues starvation against itself.
   assign dbg_granted = (state == IDLE) ? dbg_wins : (gnt == GNT_DBG);

   assign cpu_stall = cpu_req & ~cpu_ack;

   dmem_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk       (clk),
      .rst       (rst),
      .req       (dbg_req),
      .granted   (dbg_granted),
      .force_win (force_win)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         gnt       <= GNT_CPU;
         lat_cnt   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
         busy      <= 1'b0;
      end else begin
         mem_en  <= 1'b0;
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || dbg_req) begin
                  gnt       <= dbg_wins ? GNT_DBG : GNT_CPU;
                  mem_we    <= dbg_wins ? dbg_we    : cpu_we;
                  mem_addr  <= dbg_wins ? dbg_addr  : cpu_addr;
                  mem_wdata <= dbg_wins ? dbg_wdata : cpu_wdata;
                  mem_en    <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               lat_cnt <= LAT_W'(MEM_LAT - 1);
               state   <= WAIT;
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  if (!mem_we) begin
                     if (gnt == GNT_DBG) dbg_rdata <= mem_rdata;
                     else                cpu_rdata <= mem_rdata;
                  end
                  if (gnt == GNT_DBG) dbg_ack <= 1'b1;
                  else                cpu_ack <= 1'b1;
                  state <= ACK;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            ACK: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: one instance with MEM_LAT=1 (u_dut1) and one
// with MEM_LAT=3 (u_dut3), each behind a behavioural memory that only drives
// valid data in the exact cycle the latency allows.
module tb_dmem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance 1 (MEM_LAT = 1)
   logic        rst1, c1_req, c1_we, c1_ack, c1_stall, d1_req, d1_we, d1_ack;
   logic        m1_en, m1_we, busy1;
   logic [31:0] c1_addr, c1_wdata, c1_rdata, d1_addr, d1_wdata, d1_rdata;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;

   dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk(clk), .rst(rst1),
      .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
      .cpu_ack(c1_ack), .cpu_rdata(c1_rdata), .cpu_stall(c1_stall),
      .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata),
      .dbg_ack(d1_ack), .dbg_rdata(d1_rdata),
      .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
      .mem_rdata(m1_rdata), .busy(busy1));

   // ---------------- instance 3 (MEM_LAT = 3)
   logic        rst3, c3_req, c3_we, c3_ack, c3_stall, d3_req, d3_we, d3_ack;
   logic        m3_en, m3_we, busy3;
   logic [31:0] c3_addr, c3_wdata, c3_rdata, d3_addr, d3_wdata, d3_rdata;
   logic [31:0] m3_addr, m3_wdata, m3_rdata;

   dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .rst(rst3),
      .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
      .cpu_ack(c3_ack), .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
      .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr), .dbg_wdata(d3_wdata),
      .dbg_ack(d3_ack), .dbg_rdata(d3_rdata),
      .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
      .mem_rdata(m3_rdata), .busy(busy3));

   // ---------------- memory models: valid data only MEM_LAT cycles after mem_en
   logic [31:0] mem1 [logic [31:0]];
   logic [31:0] mem3 [logic [31:0]];
   logic [31:0] sch1 [int];
   logic [31:0] sch3 [int];

   always @(posedge clk) begin
      #1;
      m1_rdata = sch1.exists(cyc) ? sch1[cyc] : (32'hBAD0_0000 | 32'(cyc));
      if (m1_en) begin
         if (m1_we) mem1[m1_addr] = m1_wdata;
         else       sch1[cyc + 1] = mem1.exists(m1_addr) ? mem1[m1_addr] : 32'h0;
      end
      m3_rdata = sch3.exists(cyc) ? sch3[cyc] : (32'hBAD3_0000 | 32'(cyc));
      if (m3_en) begin
         if (m3_we) mem3[m3_addr] = m3_wdata;
         else       sch3[cyc + 3] = mem3.exists(m3_addr) ? mem3[m3_addr] : 32'h0;
      end
   end

   // ---------------- scoreboard
   typedef struct {
      bit          dbg;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ack(input bit inst3, input bit dbg, input logic [31:0] rd, input int c);
      exp_t e;
      e.dbg = dbg; e.rdata = rd; e.cyc = c;
      if (inst3) q3.push_back(e);
      else       q1.push_back(e);
   endtask

   task automatic mon(input bit inst3, input bit is_dbg, input logic [31:0] rd);
      exp_t e;
      if ((inst3 && q3.size() == 0) || (!inst3 && q1.size() == 0)) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_ack: inst%0d port dbg=%0d rdata 0x%0h at cycle %0d, none expected",
                  inst3 ? 3 : 1, is_dbg, rd, cyc);
         return;
      end
      if (inst3) e = q3.pop_front();
      else       e = q1.pop_front();
      chk("ack_port",  160'(is_dbg), 160'(e.dbg));
      chk("ack_rdata", 160'(rd),     160'(e.rdata));
      chk("ack_cycle", 160'(cyc),    160'(e.cyc));
   endtask

   always @(negedge clk) begin
      if (c1_ack) mon(1'b0, 1'b0, c1_rdata);
      if (d1_ack) mon(1'b0, 1'b1, d1_rdata);
      if (c3_ack) mon(1'b1, 1'b0, c3_rdata);
      if (d3_ack) mon(1'b1, 1'b1, d3_rdata);
   end

   // ---------------- stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset1(input string name);
      chk(name, 160'({m1_en, m1_we, m1_addr, m1_wdata, c1_ack, d1_ack, c1_rdata, d1_rdata, busy1}), 160'(0));
   endtask

   // One complete access on instance 1 with nothing else competing.
   task automatic access1(input bit dbg, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
      int c0;
      c0 = cyc;
      if (dbg) begin d1_req = 1; d1_we = we; d1_addr = a; d1_wdata = wd; end
      else     begin c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = wd; end
      expect_ack(1'b0, dbg, exp_rd, c0 + 3);
      #1;
      if (!dbg) chk("stall_req_cycle", 160'(c1_stall), 160'(1));
      tick();
      chk("mem_en_issue", 160'(m1_en), 160'(1));
      chk("mem_addr", 160'(m1_addr), 160'(a));
      chk("mem_we", 160'(m1_we), 160'(we));
      if (we) chk("mem_wdata", 160'(m1_wdata), 160'(wd));
      chk("busy_issue", 160'(busy1), 160'(1));
      tick();
      chk("mem_en_wait", 160'(m1_en), 160'(0));
      if (!dbg) chk("stall_wait", 160'(c1_stall), 160'(1));
      tick();
      if (!dbg) chk("stall_ack_cycle", 160'(c1_stall), 160'(0));
      tick();
      if (dbg) d1_req = 0;
      else     c1_req = 0;
   endtask

   initial begin
      int c0;
      rst1 = 0; rst3 = 0;
      c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
      d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0;
      c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
      d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
      m1_rdata = 0; m3_rdata = 0;
      mem1[32'h10] = 32'hDEAD_BEEF;
      mem1[32'h30] = 32'h1234_5678;
      mem1[32'h40] = 32'h4040_4040;
      mem1[32'h50] = 32'h5050_5050;
      mem3[32'h10] = 32'hCAFE_F00D;

      tick(); tick();
      chk_reset1("reset_outputs_dut1");
      chk("reset_busy_dut3", 160'({m3_en, busy3, c3_ack, c3_rdata}), 160'(0));
      rst1 = 1; rst3 = 1;
      tick(); tick();

      // basic reads and writes, single requester
      access1(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
      access1(1'b1, 1'b0, 32'h30, 32'h0, 32'h1234_5678);
      access1(1'b1, 1'b1, 32'h20, 32'hAA, 32'h1234_5678);   // rdata must not move
      access1(1'b1, 1'b0, 32'h20, 32'h0, 32'h0000_00AA);
      access1(1'b0, 1'b1, 32'h44, 32'h5555_AAAA, 32'hDEAD_BEEF);
      access1(1'b0, 1'b0, 32'h44, 32'h0, 32'h5555_AAAA);

      // starvation: both held high; expect C, D (forced), C, D (forced)
      c0 = cyc;
      c1_req = 1; c1_we = 0; c1_addr = 32'h40;
      d1_req = 1; d1_we = 0; d1_addr = 32'h50;
      expect_ack(1'b0, 1'b0, 32'h4040_4040, c0 + 3);
      expect_ack(1'b0, 1'b1, 32'h5050_5050, c0 + 7);
      expect_ack(1'b0, 1'b0, 32'h4040_4040, c0 + 11);
      expect_ack(1'b0, 1'b1, 32'h5050_5050, c0 + 15);
      for (int i = 1; i <= 16; i++) begin
         tick();
         case (i)
            1, 9:  chk("starve_grant_cpu", 160'({m1_en, m1_addr}), 160'({1'b1, 32'h40}));
            5, 13: chk("starve_grant_dbg", 160'({m1_en, m1_addr}), 160'({1'b1, 32'h50}));
            default: ;
         endcase
      end
      c1_req = 0; d1_req = 0;
      tick();

      // debug request raised during a CPU WAIT is held off until IDLE
      c0 = cyc;
      c1_req = 1; c1_we = 0; c1_addr = 32'h10;
      expect_ack(1'b0, 1'b0, 32'hDEAD_BEEF, c0 + 3);
      expect_ack(1'b0, 1'b1, 32'h0000_00AA, c0 + 7);
      tick(); tick();
      d1_req = 1; d1_we = 0; d1_addr = 32'h20;
      tick();
      chk("late_req_ignored_ack", 160'(m1_en), 160'(0));
      tick();
      c1_req = 0;
      tick();
      chk("late_req_granted", 160'({m1_en, m1_addr}), 160'({1'b1, 32'h20}));
      tick(); tick(); tick();
      d1_req = 0;
      tick();

      // asynchronous reset in WAIT aborts the access without an ack
      c1_req = 1; c1_we = 0; c1_addr = 32'h10;
      tick(); tick();
      chk("busy_before_abort", 160'(busy1), 160'(1));
      rst1 = 0;
      #1;
      chk_reset1("async_reset_outputs");
      c1_req = 0;
      tick(); tick(); tick();
      chk_reset1("reset_held_outputs");
      rst1 = 1;
      tick();
      access1(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);

      // MEM_LAT = 3 instance
      c0 = cyc;
      c3_req = 1; c3_we = 0; c3_addr = 32'h10;
      expect_ack(1'b1, 1'b0, 32'hCAFE_F00D, c0 + 5);
      tick();
      chk("lat3_mem_en_issue", 160'({m3_en, m3_addr}), 160'({1'b1, 32'h10}));
      tick();
      chk("lat3_mem_en_wait", 160'(m3_en), 160'(0));
      tick(); tick(); tick();
      chk("lat3_stall_ack_cycle", 160'(c3_stall), 160'(0));
      tick();
      c3_req = 0;

      tick(); tick(); tick();
      chk("pending_acks_dut1", 160'(q1.size()), 160'(0));
      chk("pending_acks_dut3", 160'(q3.size()), 160'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
